// File: rtl/aes_pkg.sv
// Shared types, GF(2^8) arithmetic and byte-layout helpers for the AES-128 cipher datapath.
// Byte n of a 128-bit state lives at bits [127-8n -: 8]; column c is bytes 4c..4c+3.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  localparam int    NR        = 10;
  localparam byte_t RCON_INIT = 8'h01;

  function automatic byte_t get_byte(state_t s, int n);
    return s[127-8*n -: 8];
  endfunction

  function automatic byte_t xtime(byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Source byte for ShiftRows output byte n: row r of column c comes from column (c+r) mod 4.
  function automatic int shift_src(int n);
    int c;
    int r;
    c = n / 4;
    r = n % 4;
    return 4 * ((c + r) % 4) + r;
  endfunction

  function automatic word_t mix_column(word_t col);
    byte_t a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
            gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, table lookup.
// Entry 0 sits in the top byte of the table so rows read in the usual FIPS order.
module aes_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_ofs;

  assign w_bit_ofs = {i_data, 3'b000};
  assign o_data    = SBOX_TABLE[11'd2047 - w_bit_ofs -: 8];

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
//   state   | meaning
//   IDLE    | waiting for a plaintext/key pair, in_ready high
//   BUSY    | applying rounds 1..10, one per clock
//   DONE    | ciphertext presented, waiting for out_ready
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [3:0]   r_round;
  state_t       r_state;
  state_t       r_rkey;
  byte_t        r_rcon;
  logic         r_in_ready;
  logic         r_out_valid;
  state_t       r_out_data;
  logic         r_busy;

  logic         w_accept;
  logic         w_last;
  logic         w_release;
  logic         w_illegal;

  state_t       w_sub;
  state_t       w_shifted;
  state_t       w_mixed;
  word_t        w_rot;
  word_t        w_subrot;
  word_t        w_k0, w_k1, w_k2, w_k3;
  state_t       w_key_next;
  state_t       w_round_out;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sbox_state
      aes_sbox u_sbox (
        .i_data (r_state[127-8*gi -: 8]),
        .o_data (w_sub[127-8*gi -: 8])
      );
    end
    for (gi = 0; gi < 4; gi++) begin : g_sbox_key
      aes_sbox u_sbox (
        .i_data (w_rot[31-8*gi -: 8]),
        .o_data (w_subrot[31-8*gi -: 8])
      );
    end
  endgenerate

  // r_rkey holds rk[round-1]; the next round key is derived combinationally from it.
  assign w_rot      = rot_word(r_rkey[31:0]);
  assign w_k0       = r_rkey[127:96] ^ w_subrot ^ {r_rcon, 24'h000000};
  assign w_k1       = r_rkey[95:64] ^ w_k0;
  assign w_k2       = r_rkey[63:32] ^ w_k1;
  assign w_k3       = r_rkey[31:0]  ^ w_k2;
  assign w_key_next = {w_k0, w_k1, w_k2, w_k3};

  always_comb begin
    w_shifted = '0;
    for (int n = 0; n < 16; n++) begin
      w_shifted[127-8*n -: 8] = get_byte(w_sub, shift_src(n));
    end
    w_mixed = '0;
    for (int c = 0; c < 4; c++) begin
      w_mixed[127-32*c -: 32] = mix_column(w_shifted[127-32*c -: 32]);
    end
  end

  assign w_round_out = ((r_round == 4'(NR)) ? w_shifted : w_mixed) ^ w_key_next;

  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_release  = 1'b0;
    w_illegal  = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept   = 1'b1;
          w_fsm_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_round == 4'(NR)) begin
          w_last     = 1'b1;
          w_fsm_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_out_valid && out_ready) begin
          w_release  = 1'b1;
          w_fsm_next = ST_IDLE;
        end
      end
      default: begin
        w_illegal  = 1'b1;
        w_fsm_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round     <= 4'd0;
      r_state     <= '0;
      r_rkey      <= '0;
      r_rcon      <= RCON_INIT;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_state    <= in_data ^ in_key;
      r_rkey     <= in_key;
      r_round    <= 4'd1;
      r_rcon     <= RCON_INIT;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else if (r_fsm == ST_BUSY) begin
      r_state <= w_round_out;
      r_rkey  <= w_key_next;
      r_rcon  <= xtime(r_rcon);
      if (w_last) begin
        r_out_data  <= w_round_out;
        r_out_valid <= 1'b1;
      end else begin
        r_round <= r_round + 4'd1;
      end
    end else if (w_release) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_round     <= 4'd0;
      r_rcon      <= RCON_INIT;
      // out_data deliberately survives zeroization; only working secrets are wiped.
      if (ZEROIZE) begin
        r_state <= '0;
        r_rkey  <= '0;
      end
    end else if (w_illegal) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_round     <= 4'd0;
      r_rcon      <= RCON_INIT;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
